dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, dmem word-address width.
REQ-002 Parameter DATA_W, default 32, dmem data width.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 p_req  in  1  processor requester: access request.
REQ-006 p_we  in  1  processor: 1 = write, 0 = read.
REQ-007 p_addr  in  ADDR_W  processor word address.
REQ-008 p_wdata  in  DATA_W  processor write data.
REQ-009 p_ack  out  1  processor: one-cycle completion pulse.
REQ-010 p_rdata  out  DATA_W  processor read data, valid while p_ack=1.
REQ-011 l_req, l_we, l_addr, l_wdata, l_ack, l_rdata: loader requester, same directions, widths and meanings as REQ-005..REQ-010.
REQ-012 address_dmem  out  ADDR_W  dmem address.
REQ-013 data  out  DATA_W  dmem write data.
REQ-014 wren  out  1  dmem write enable.
REQ-015 q_dmem  in  DATA_W  dmem read data, valid one cycle after address_dmem is presented.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: no req -> stay; any req -> register winner (owner), its we/addr/wdata; go ISSUE.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both requesting -> the requester not served last wins; last_served resets to loader, so processor wins the first tie.
REQ-020 ISSUE: address_dmem/data SHALL come from the registered request; wren = registered we for this cycle only; go WAIT.
REQ-021 WAIT: address_dmem held, wren=0; q_dmem SHALL be captured into rdata register at end of cycle; go DONE.
REQ-022 DONE: ack of owner SHALL be 1 for exactly this cycle, other ack 0; owner's rdata = captured value (writes: value read back at same address, don't-care); update last_served=owner; go IDLE.
REQ-023 Latency: req sampled in IDLE at edge N -> ack high in cycle N+3; throughput at most one access per 4 cycles.
REQ-024 Requesters SHALL hold req/we/addr/wdata stable through the ack cycle and drop req after it; a req still high in IDLE is a new request.
REQ-025 Changes of the losing or non-owner requester's inputs during ISSUE/WAIT/DONE SHALL not affect the in-flight access.
REQ-026 wren SHALL never be 1 outside ISSUE; at most one wren pulse per granted access.
REQ-027 Non-owner ack SHALL remain 0; non-owner rdata SHALL hold its last value.
REQ-028 Outside ISSUE/WAIT address_dmem and data SHALL hold last registered values.

Reset
REQ-029 reset low SHALL immediately force: state=IDLE, p_ack=l_ack=0, wren=0, busy=0, address_dmem=0, data=0, p_rdata=l_rdata=0, last_served=loader.
REQ-030 Reset in ISSUE SHALL abort the write (wren drops asynchronously); the in-flight access SHALL never be acknowledged.
REQ-031 After reset rises, first arbitration SHALL occur at the next rising edge with any req high.

Structure
REQ-032 State encoding and ADDR_W/DATA_W defaults SHALL live in a shared package with the processor constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_picker2 (inputs two reqs and last_served, output winner index and valid); FSM and datapath registers in dmem_arbiter.

Verification
REQ-034 Processor write alone: p_req=1, p_we=1, p_addr=0x010, p_wdata=0xDEADBEEF -> wren=1 one cycle with address_dmem=0x010, data=0xDEADBEEF; p_ack 3 cycles after sampling.
REQ-035 Loader read after write: l_req=1, l_we=0, l_addr=0x010 -> l_ack after 3 cycles with l_rdata=0xDEADBEEF; p_ack stays 0.
REQ-036 Tie after reset: both req at once -> processor served first, loader next, repeated held reqs alternate P,L,P,L with acks every 4 cycles.
REQ-037 Non-owner changes: during processor access toggle l_addr/l_wdata each cycle -> address_dmem/data unchanged until DONE.
REQ-038 Reset in ISSUE of write to 0x020 with data 0x12345678 -> wren falls immediately, no ack, subsequent read of 0x020 returns prior contents.
REQ-039 Idle check: no req for 20 cycles -> busy=0, wren=0, both acks 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dmem arbiter: default widths, FSM states and
// the requester index encoding used for ownership and round-robin history.
package dmem_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic OWNER_P = 1'b0;
   localparam logic OWNER_L = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_picker2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_picker2
   import dmem_arbiter_pkg::*;
(
   input  logic req_p,
   input  logic req_l,
   input  logic last_served,
   output logic winner,
   output logic valid
);

   always_comb begin
      valid  = req_p | req_l;
      winner = OWNER_P;
      if (req_p && req_l) begin
         winner = ~last_served;
      end else if (req_l) begin
         winner = OWNER_L;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a processor and a loader onto one synchronous-read dmem port;
// each granted access walks IDLE -> ISSUE -> WAIT -> DONE.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_ack,
   output logic [DATA_W-1:0] p_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_ack,
   output logic [DATA_W-1:0] l_rdata,
   output logic [ADDR_W-1:0] address_dmem,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   input  logic [DATA_W-1:0] q_dmem,
   output logic              busy
);

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
   logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
   logic                last_served_q, last_served_d;
   logic                pick_winner;
   logic                pick_valid;

   rr_picker2 u_picker (
      .req_p       (p_req),
      .req_l       (l_req),
      .last_served (last_served_q),
      .winner      (pick_winner),
      .valid       (pick_valid)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         owner_q       <= OWNER_P;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         p_rdata_q     <= '0;
         l_rdata_q     <= '0;
         last_served_q <= OWNER_L;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         p_rdata_q     <= p_rdata_d;
         l_rdata_q     <= l_rdata_d;
         last_served_q <= last_served_d;
      end
   end

   // Only the IDLE sample touches requester inputs, so later input changes
   // cannot disturb an access already in flight.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      p_rdata_d     = p_rdata_q;
      l_rdata_d     = l_rdata_q;
      last_served_d = last_served_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_winner;
               we_d    = (pick_winner == OWNER_L) ? l_we    : p_we;
               addr_d  = (pick_winner == OWNER_L) ? l_addr  : p_addr;
               wdata_d = (pick_winner == OWNER_L) ? l_wdata : p_wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (owner_q == OWNER_L) begin
               l_rdata_d = q_dmem;
            end else begin
               p_rdata_d = q_dmem;
            end
            state_d = DONE;
         end
         DONE: begin
            last_served_d = owner_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // wren decodes straight from the state flop so an async reset kills it at once.
   always_comb begin
      wren         = (state_q == ISSUE) && we_q;
      p_ack        = (state_q == DONE) && (owner_q == OWNER_P);
      l_ack        = (state_q == DONE) && (owner_q == OWNER_L);
      busy         = (state_q != IDLE);
      address_dmem = addr_q;
      data         = wdata_q;
      p_rdata      = p_rdata_q;
      l_rdata      = l_rdata_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and a
// transaction-level reference model of arbitration and memory contents.
module tb_dmem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic          p_req, p_we, l_req, l_we;
   logic [AW-1:0] p_addr, l_addr;
   logic [DW-1:0] p_wdata, l_wdata;
   logic          p_ack, l_ack, wren, busy;
   logic [DW-1:0] p_rdata, l_rdata, data, q_dmem;
   logic [AW-1:0] address_dmem;

   logic [DW-1:0] mem    [0:(1<<AW)-1];
   logic [DW-1:0] refMem [0:(1<<AW)-1];
   bit            lastServed;
   logic [DW-1:0] expP, expL;

   int testsRun;
   int testsFailed;

   typedef struct {
      bit            pReq;
      bit            pWe;
      logic [AW-1:0] pAddr;
      logic [DW-1:0] pWdata;
      bit            lReq;
      bit            lWe;
      logic [AW-1:0] lAddr;
      logic [DW-1:0] lWdata;
      bit            expOwner;
      logic [DW-1:0] expRdata;
      string         name;
   } vec_t;

   vec_t vecs [8];

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .p_req        (p_req),
      .p_we         (p_we),
      .p_addr       (p_addr),
      .p_wdata      (p_wdata),
      .p_ack        (p_ack),
      .p_rdata      (p_rdata),
      .l_req        (l_req),
      .l_we         (l_we),
      .l_addr       (l_addr),
      .l_wdata      (l_wdata),
      .l_ack        (l_ack),
      .l_rdata      (l_rdata),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .busy         (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous dmem: read-before-write, data valid one cycle after the address.
   always @(posedge clock) begin
      if (wren) mem[address_dmem] <= data;
      q_dmem <= mem[address_dmem];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One granted access from IDLE: checks the dmem port, latency, acks and
   // read data, then advances the reference model.
   task automatic applyStimulus(input bit pReq, input bit pWe, input logic [AW-1:0] pAddr,
                                input logic [DW-1:0] pWdata, input bit lReq, input bit lWe,
                                input logic [AW-1:0] lAddr, input logic [DW-1:0] lWdata,
                                input bit expOwner, input logic [DW-1:0] expRdata,
                                input string name);
      logic [AW-1:0] wAddr;
      logic [DW-1:0] wData;
      bit            wWe;
      bit            acked;
      p_req = pReq; p_we = pWe; p_addr = pAddr; p_wdata = pWdata;
      l_req = lReq; l_we = lWe; l_addr = lAddr; l_wdata = lWdata;
      wAddr = expOwner ? lAddr  : pAddr;
      wData = expOwner ? lWdata : pWdata;
      wWe   = expOwner ? lWe    : pWe;
      acked = 1'b0;
      for (int k = 1; k <= 6 && !acked; k++) begin
         tick();
         checkOutput({name, " wren"}, 64'(wren), (k == 1) ? 64'(wWe) : 64'd0);
         checkOutput({name, " addr"}, 64'(address_dmem), 64'(wAddr));
         checkOutput({name, " wdata"}, 64'(data), 64'(wData));
         checkOutput({name, " busy"}, 64'(busy), 64'd1);
         if (p_ack || l_ack) begin
            acked = 1'b1;
            checkOutput({name, " latency"}, 64'(k), 64'd3);
            checkOutput({name, " acks"}, {62'd0, p_ack, l_ack}, expOwner ? 64'd1 : 64'd2);
            checkOutput({name, " owner rdata"}, expOwner ? 64'(l_rdata) : 64'(p_rdata), 64'(expRdata));
            checkOutput({name, " other rdata"}, expOwner ? 64'(p_rdata) : 64'(l_rdata),
                        expOwner ? 64'(expP) : 64'(expL));
         end
         if (expOwner) begin
            p_addr = ~p_addr; p_wdata = ~p_wdata;
         end else begin
            l_addr = ~l_addr; l_wdata = ~l_wdata;
         end
      end
      if (!acked) checkOutput({name, " ack timeout"}, 64'd0, 64'd1);
      tick();
      p_req = 1'b0; l_req = 1'b0;
      checkOutput({name, " idle after"}, {61'd0, busy, p_ack, l_ack}, 64'd0);
      if (expOwner) expL = expRdata; else expP = expRdata;
      lastServed = expOwner;
      if (wWe) refMem[wAddr] = wData;
   endtask

   initial begin
      bit            pr, lr, pw, lw, own;
      logic [AW-1:0] pa, la;
      logic [DW-1:0] pd, ld;

      testsRun = 0; testsFailed = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]    = 32'hA5A50000 | 32'(i);
         refMem[i] = 32'hA5A50000 | 32'(i);
      end
      lastServed = 1'b1; expP = '0; expL = '0;
      p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
      reset = 1'b0;

      vecs[0] = '{1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,        0, 32'hA5A50010, "p write 010"};
      vecs[1] = '{0, 0, 12'h000, 32'h0,        1, 0, 12'h010, 32'h0,        1, 32'hDEADBEEF, "l read 010"};
      vecs[2] = '{1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        0, 32'hDEADBEEF, "p read 010"};
      vecs[3] = '{1, 1, 12'h011, 32'h11111111, 1, 1, 12'h012, 32'h22222222, 1, 32'hA5A50012, "tie l wins"};
      vecs[4] = '{1, 0, 12'h012, 32'h0,        1, 0, 12'h011, 32'h0,        0, 32'h22222222, "tie p wins"};
      vecs[5] = '{0, 0, 12'h000, 32'h0,        1, 1, 12'h3FF, 32'hCAFEF00D, 1, 32'hA5A503FF, "l write 3ff"};
      vecs[6] = '{1, 0, 12'h3FF, 32'h0,        1, 0, 12'h010, 32'h0,        0, 32'hCAFEF00D, "tie p read 3ff"};
      vecs[7] = '{1, 0, 12'hFFF, 32'h0,        0, 0, 12'h000, 32'h0,        0, 32'hA5A50FFF, "p read fff"};

      tick(); tick();
      checkOutput("reset state", {busy, wren, p_ack, l_ack, 12'(address_dmem), data, 16'd0},
                  64'd0);
      checkOutput("reset rdata", {p_rdata, l_rdata}, 64'd0);
      @(negedge clock); reset = 1'b1;
      tick();

      // Held tie after reset: P, L, P, L with acks four cycles apart.
      p_req = 1; p_we = 0; p_addr = 12'h005;
      l_req = 1; l_we = 0; l_addr = 12'h006;
      for (int c = 1; c <= 15; c++) begin
         tick();
         checkOutput($sformatf("tie ack c%0d", c), {62'd0, p_ack, l_ack},
                     {62'd0, (c == 3 || c == 11), (c == 7 || c == 15)});
         if (c == 3)  checkOutput("tie p rdata", 64'(p_rdata), 64'hA5A50005);
         if (c == 7)  checkOutput("tie l rdata", 64'(l_rdata), 64'hA5A50006);
      end
      tick();
      p_req = 0; l_req = 0;
      expP = 32'hA5A50005; expL = 32'hA5A50006; lastServed = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].pReq, vecs[i].pWe, vecs[i].pAddr, vecs[i].pWdata,
                       vecs[i].lReq, vecs[i].lWe, vecs[i].lAddr, vecs[i].lWdata,
                       vecs[i].expOwner, vecs[i].expRdata, vecs[i].name);
      end

      // Reset while a write is in ISSUE: write aborted, never acknowledged.
      p_req = 1; p_we = 1; p_addr = 12'h020; p_wdata = 32'h12345678;
      tick();
      checkOutput("issue wren", 64'(wren), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("async reset", {busy, wren, p_ack, l_ack, 12'(address_dmem), data, 16'd0}, 64'd0);
      checkOutput("async reset rdata", {p_rdata, l_rdata}, 64'd0);
      p_req = 0;
      tick();
      @(negedge clock); reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checkOutput("no ack after abort", {61'd0, busy, p_ack, l_ack}, 64'd0);
      end
      lastServed = 1'b1; expP = '0; expL = '0;
      applyStimulus(1, 0, 12'h020, 32'h0, 1, 0, 12'h021, 32'h0, 0, refMem[12'h020], "read 020 after abort");

      for (int i = 0; i < 40; i++) begin
         pr = 1'($urandom_range(0, 1)); lr = 1'($urandom_range(0, 1));
         if (!pr && !lr) pr = 1'b1;
         pw = 1'($urandom_range(0, 1)); lw = 1'($urandom_range(0, 1));
         pa = 12'h040 + 12'($urandom_range(0, 7)); la = 12'h040 + 12'($urandom_range(0, 7));
         pd = $urandom; ld = $urandom;
         own = (pr && lr) ? !lastServed : lr;
         applyStimulus(pr, pw, pa, pd, lr, lw, la, ld, own, refMem[own ? la : pa],
                       $sformatf("rand %0d", i));
      end

      for (int c = 0; c < 20; c++) begin
         tick();
         checkOutput("idle quiet", {60'd0, busy, wren, p_ack, l_ack}, 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
